id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/data width.
REQ-002 SHALL have parameter: NUM_FWD, 2, number of forwarding sources (index 0 = EX stage, highest priority).
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: pc_i  in  32  instruction address; inst_i  in  32  instruction word; id_valid_i  in  1  IF/ID holds a valid instruction.
REQ-006 SHALL have ports: reg1_data_i, reg2_data_i  in  DATA_W  regfile read data.
REQ-007 SHALL have ports: reg1_addr_o, reg2_addr_o  out  5  = inst_i[25:21], inst_i[20:16]; reg1_read_o, reg2_read_o  out  1  read enables (combinational).
REQ-008 SHALL have ports: fwd_wreg_i  in  NUM_FWD; fwd_wd_i  in  5*NUM_FWD; fwd_wdata_i  in  DATA_W*NUM_FWD; packed, source j in slice j.
REQ-009 SHALL have ports: ex_load_i  in  1  instruction in EX is a load; stall_i  in  1  hold; flush_i  in  1  kill.
REQ-010 SHALL have port: stallreq_o  out  1  load-use stall request (combinational).
REQ-011 SHALL have registered ports: ex_aluop_o 8, ex_alusel_o 3, ex_reg1_o DATA_W, ex_reg2_o DATA_W, ex_wd_o 5, ex_wreg_o 1, ex_pc_o 32, ex_invalid_o 1.

Function
REQ-012 SHALL decode and/or/xor/nor (op 0, sa 0, funct 0x24/0x25/0x26/0x27): both regs read, alusel logic, wd = rd.
REQ-013 SHALL decode andi/ori/xori (op 0x0C/0x0D/0x0E): reg1 read, operand2 = zero-extended imm16, wd = rt.
REQ-014 SHALL decode lui (op 0x0F): no reg read, operand1 = 0, operand2 = {imm16,16'h0}, aluop OR, wd = rt.
REQ-015 SHALL use shared-defines encodings (EXE_*_OP, EXE_RES_*) for aluop/alusel.
REQ-016 SHALL treat inst_i = 0 as bubble with ex_invalid_o = 0.
REQ-017 SHALL decode any other word as invalid: aluop/alusel NOP, wreg 0, ex_invalid_o = 1.
REQ-018 SHALL force wreg = 0 whenever destination is register 0.
REQ-019 SHALL resolve each operand with read=1: addr 0 -> 0; else lowest j with fwd_wreg_i[j] and fwd_wd_i[j]==addr -> fwd_wdata_i[j]; else regfile data. read=0 -> immediate/constant per decode.
REQ-020 SHALL assert stallreq_o = id_valid_i & ex_load_i & fwd_wreg_i[0] & (match of fwd_wd_i[0] with a nonzero read address of either operand).
REQ-021 SHALL update ex_* registers each edge with priority: rst > flush_i (bubble) > stall_i (hold) > stallreq_o (bubble) > !id_valid_i (bubble) > decoded result.
REQ-022 SHALL define bubble as all ex_* outputs zero.
REQ-023 SHALL have latency of exactly 1 cycle from inst_i to ex_* outputs.
REQ-024 SHALL let simultaneous flush_i and stall_i produce a bubble.

Reset
REQ-025 SHALL zero all ex_* registers on the edge where rst=1, overriding stall/flush, including mid-stall.
REQ-026 SHALL drive reg*_read_o = 0 and stallreq_o = 0 while rst=1.

Configuration
REQ-027 SHALL provide macro SHIFT_INSTR_EN; when defined, decode sll/srl/sra (funct 0x00/0x02/0x03, rs 0: operand1 = zero-extended sa, operand2 = rt) and sllv/srlv/srav (funct 0x04/0x06/0x07, sa 0: operand1 = rs, operand2 = rt), alusel shift, wd = rd.
REQ-028 SHALL, without SHIFT_INSTR_EN, decode those words as invalid per REQ-017 (REQ-016 still applies).

Verification
REQ-029 SHALL cover: inst 0x34011100 (ori $1,$0,0x1100), valid -> next cycle ex_reg1_o=0, ex_reg2_o=0x00001100, ex_wd_o=1, ex_wreg_o=1.
REQ-030 SHALL cover: inst 0x00221824 (and $3,$1,$2), fwd0 wd=1 data 0xAAAA0000, fwd1 wd=1 data 0x00005555, reg2_data 0x0F -> ex_reg1_o=0xAAAA0000, ex_reg2_o=0x0F.
REQ-031 SHALL cover: same inst, ex_load_i=1, fwd_wreg_i[0]=1, fwd_wd_i[0]=2 -> stallreq_o=1 same cycle, next cycle all ex_* = 0.
REQ-032 SHALL cover: stall_i=1 for 3 cycles after valid ori -> ex_* unchanged; then flush_i=1 -> ex_* all 0.
REQ-033 SHALL cover: inst 0x00011100 (sll $2,$1,4) -> with SHIFT_INSTR_EN ex_reg1_o=4, ex_wd_o=2, ex_wreg_o=1; without -> ex_invalid_o=1, ex_wreg_o=0.
REQ-034 SHALL cover: rst=1 during stall_i=1 with nonzero ex_* -> all ex_* = 0 next cycle.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID inputs, regfile read port, forwarding sources,
// pipeline control and the registered ID/EX outputs.
interface id_stage_pipe_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_FWD = 2
);
   logic [31:0]             pc_i;
   logic [31:0]             inst_i;
   logic                    id_valid_i;
   logic [DATA_W-1:0]       reg1_data_i;
   logic [DATA_W-1:0]       reg2_data_i;
   logic [4:0]              reg1_addr_o;
   logic [4:0]              reg2_addr_o;
   logic                    reg1_read_o;
   logic                    reg2_read_o;
   logic [NUM_FWD-1:0]      fwd_wreg_i;
   logic [5*NUM_FWD-1:0]    fwd_wd_i;
   logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i;
   logic                    ex_load_i;
   logic                    stall_i;
   logic                    flush_i;
   logic                    stallreq_o;
   logic [7:0]              ex_aluop_o;
   logic [2:0]              ex_alusel_o;
   logic [DATA_W-1:0]       ex_reg1_o;
   logic [DATA_W-1:0]       ex_reg2_o;
   logic [4:0]              ex_wd_o;
   logic                    ex_wreg_o;
   logic [31:0]             ex_pc_o;
   logic                    ex_invalid_o;

   modport master (
      output pc_i, inst_i, id_valid_i, reg1_data_i, reg2_data_i,
      output fwd_wreg_i, fwd_wd_i, fwd_wdata_i, ex_load_i, stall_i, flush_i,
      input  reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o, stallreq_o,
      input  ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
      input  ex_pc_o, ex_invalid_o
   );

   modport slave (
      input  pc_i, inst_i, id_valid_i, reg1_data_i, reg2_data_i,
      input  fwd_wreg_i, fwd_wd_i, fwd_wdata_i, ex_load_i, stall_i, flush_i,
      output reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o, stallreq_o,
      output ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o,
      output ex_pc_o, ex_invalid_o
   );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-style decode stage: logic/lui decode, operand forwarding, load-use stall and ID/EX
// register. Define SHIFT_INSTR_EN to also decode sll/srl/sra/sllv/srlv/srav.
module id_stage_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_FWD = 2
) (
   input logic            clk,
   input logic            rst,
   id_stage_pipe_if.slave bus
);

   localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
`ifdef SHIFT_INSTR_EN
   localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
   localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
`endif
   localparam logic [2:0] EXE_RES_NOP   = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
`ifdef SHIFT_INSTR_EN
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
`endif

   typedef struct packed {
      logic [7:0]        aluop;
      logic [2:0]        alusel;
      logic [DATA_W-1:0] reg1;
      logic [DATA_W-1:0] reg2;
      logic [4:0]        wd;
      logic              wreg;
      logic [31:0]       pc;
      logic              invalid;
   } ex_t;

   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        sa;
   logic [4:0]        rd;
   logic [15:0]       imm16;
   logic [4:0]        reg1_addr;
   logic [4:0]        reg2_addr;

   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic [4:0]        dec_wd;
   logic              dec_wreg;
   logic              dec_read1;
   logic              dec_read2;
   logic [DATA_W-1:0] dec_imm1;
   logic [DATA_W-1:0] dec_imm2;
   logic              dec_invalid;
   logic              dec_bubble;

   logic              read1;
   logic              read2;
   logic [DATA_W-1:0] opnd1;
   logic [DATA_W-1:0] opnd2;
   logic              load_hit;
   logic              stallreq;

   ex_t               ex_dec;
   ex_t               ex_d;
   ex_t               ex_q;

   assign op        = bus.inst_i[31:26];
   assign reg1_addr = bus.inst_i[25:21];
   assign reg2_addr = bus.inst_i[20:16];
   assign rd        = bus.inst_i[15:11];
   assign sa        = bus.inst_i[10:6];
   assign funct     = bus.inst_i[5:0];
   assign imm16     = bus.inst_i[15:0];

   always_comb begin
      dec_aluop   = EXE_NOP_OP;
      dec_alusel  = EXE_RES_NOP;
      dec_wd      = 5'd0;
      dec_wreg    = 1'b0;
      dec_read1   = 1'b0;
      dec_read2   = 1'b0;
      dec_imm1    = '0;
      dec_imm2    = '0;
      dec_invalid = 1'b0;
      dec_bubble  = 1'b0;
      if (bus.inst_i == 32'h0) begin
         dec_bubble = 1'b1;
      end else begin
         // Cleared by each recognised encoding below.
         dec_invalid = 1'b1;
         case (op)
            OP_SPECIAL: begin
               case (funct)
                  F_AND, F_OR, F_XOR, F_NOR: begin
                     if (sa == 5'd0) begin
                        dec_invalid = 1'b0;
                        dec_alusel  = EXE_RES_LOGIC;
                        dec_read1   = 1'b1;
                        dec_read2   = 1'b1;
                        dec_wd      = rd;
                        dec_wreg    = 1'b1;
                        case (funct)
                           F_AND:   dec_aluop = EXE_AND_OP;
                           F_OR:    dec_aluop = EXE_OR_OP;
                           F_XOR:   dec_aluop = EXE_XOR_OP;
                           default: dec_aluop = EXE_NOR_OP;
                        endcase
                     end
                  end
`ifdef SHIFT_INSTR_EN
                  F_SLL, F_SRL, F_SRA: begin
                     if (reg1_addr == 5'd0) begin
                        dec_invalid = 1'b0;
                        dec_alusel  = EXE_RES_SHIFT;
                        dec_imm1    = DATA_W'(sa);
                        dec_read2   = 1'b1;
                        dec_wd      = rd;
                        dec_wreg    = 1'b1;
                        case (funct)
                           F_SLL:   dec_aluop = EXE_SLL_OP;
                           F_SRL:   dec_aluop = EXE_SRL_OP;
                           default: dec_aluop = EXE_SRA_OP;
                        endcase
                     end
                  end
                  F_SLLV, F_SRLV, F_SRAV: begin
                     if (sa == 5'd0) begin
                        dec_invalid = 1'b0;
                        dec_alusel  = EXE_RES_SHIFT;
                        dec_read1   = 1'b1;
                        dec_read2   = 1'b1;
                        dec_wd      = rd;
                        dec_wreg    = 1'b1;
                        case (funct)
                           F_SLLV:  dec_aluop = EXE_SLL_OP;
                           F_SRLV:  dec_aluop = EXE_SRL_OP;
                           default: dec_aluop = EXE_SRA_OP;
                        endcase
                     end
                  end
`endif
                  default: ;
               endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
               dec_invalid = 1'b0;
               dec_alusel  = EXE_RES_LOGIC;
               dec_read1   = 1'b1;
               dec_imm2    = DATA_W'(imm16);
               dec_wd      = reg2_addr;
               dec_wreg    = 1'b1;
               case (op)
                  OP_ANDI: dec_aluop = EXE_AND_OP;
                  OP_ORI:  dec_aluop = EXE_OR_OP;
                  default: dec_aluop = EXE_XOR_OP;
               endcase
            end
            OP_LUI: begin
               dec_invalid = 1'b0;
               dec_alusel  = EXE_RES_LOGIC;
               dec_aluop   = EXE_OR_OP;
               dec_imm2    = DATA_W'({imm16, 16'h0});
               dec_wd      = reg2_addr;
               dec_wreg    = 1'b1;
            end
            default: ;
         endcase
         // Writes to $0 are architecturally discarded.
         if (dec_wd == 5'd0) begin
            dec_wreg = 1'b0;
         end
      end
   end

   assign read1 = dec_read1 & ~rst;
   assign read2 = dec_read2 & ~rst;

   // Scan from the highest index down so the lowest matching source wins.
   always_comb begin
      opnd1 = dec_imm1;
      if (read1) begin
         if (reg1_addr == 5'd0) begin
            opnd1 = '0;
         end else begin
            opnd1 = bus.reg1_data_i;
            for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
               if (bus.fwd_wreg_i[j] && (bus.fwd_wd_i[5*j +: 5] == reg1_addr)) begin
                  opnd1 = bus.fwd_wdata_i[DATA_W*j +: DATA_W];
               end
            end
         end
      end
   end

   always_comb begin
      opnd2 = dec_imm2;
      if (read2) begin
         if (reg2_addr == 5'd0) begin
            opnd2 = '0;
         end else begin
            opnd2 = bus.reg2_data_i;
            for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
               if (bus.fwd_wreg_i[j] && (bus.fwd_wd_i[5*j +: 5] == reg2_addr)) begin
                  opnd2 = bus.fwd_wdata_i[DATA_W*j +: DATA_W];
               end
            end
         end
      end
   end

   // A load in EX cannot forward yet; hold the consumer for one cycle.
   always_comb begin
      load_hit = 1'b0;
      if (bus.ex_load_i && bus.fwd_wreg_i[0]) begin
         if (read1 && (reg1_addr != 5'd0) && (bus.fwd_wd_i[4:0] == reg1_addr)) begin
            load_hit = 1'b1;
         end
         if (read2 && (reg2_addr != 5'd0) && (bus.fwd_wd_i[4:0] == reg2_addr)) begin
            load_hit = 1'b1;
         end
      end
   end

   assign stallreq = ~rst & bus.id_valid_i & load_hit;

   always_comb begin
      ex_dec.aluop   = dec_aluop;
      ex_dec.alusel  = dec_alusel;
      ex_dec.reg1    = opnd1;
      ex_dec.reg2    = opnd2;
      ex_dec.wd      = dec_wd;
      ex_dec.wreg    = dec_wreg;
      ex_dec.pc      = bus.pc_i;
      ex_dec.invalid = dec_invalid;
      if (dec_bubble) begin
         ex_dec = '0;
      end
   end

   always_comb begin
      ex_d = ex_dec;
      if (bus.flush_i) begin
         ex_d = '0;
      end else if (bus.stall_i) begin
         ex_d = ex_q;
      end else if (stallreq || !bus.id_valid_i) begin
         ex_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.reg1_addr_o  = reg1_addr;
   assign bus.reg2_addr_o  = reg2_addr;
   assign bus.reg1_read_o  = read1;
   assign bus.reg2_read_o  = read2;
   assign bus.stallreq_o   = stallreq;
   assign bus.ex_aluop_o   = ex_q.aluop;
   assign bus.ex_alusel_o  = ex_q.alusel;
   assign bus.ex_reg1_o    = ex_q.reg1;
   assign bus.ex_reg2_o    = ex_q.reg2;
   assign bus.ex_wd_o      = ex_q.wd;
   assign bus.ex_wreg_o    = ex_q.wreg;
   assign bus.ex_pc_o      = ex_q.pc;
   assign bus.ex_invalid_o = ex_q.invalid;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected ID/EX contents are queued as each
// instruction is driven and compared one cycle later.
module tb_id_stage_pipe;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] pc;
      logic        inv;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];
   string sb_tag[$];

   id_stage_pipe_if #(.DATA_W(32), .NUM_FWD(2)) bus ();

   id_stage_pipe #(.DATA_W(32), .NUM_FWD(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] aluop, input logic [2:0] alusel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] pc, input logic inv);
      exp_t e;
      e.aluop = aluop; e.alusel = alusel; e.reg1 = r1; e.reg2 = r2;
      e.wd = wd; e.wreg = wreg; e.pc = pc; e.inv = inv;
      return e;
   endfunction

   task automatic expect_ex(input string tag, input exp_t e);
      sb.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic tick();
      exp_t  e;
      string t;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         t = sb_tag.pop_front();
         check({t, ".aluop"},   64'(bus.ex_aluop_o),   64'(e.aluop));
         check({t, ".alusel"},  64'(bus.ex_alusel_o),  64'(e.alusel));
         check({t, ".reg1"},    64'(bus.ex_reg1_o),    64'(e.reg1));
         check({t, ".reg2"},    64'(bus.ex_reg2_o),    64'(e.reg2));
         check({t, ".wd"},      64'(bus.ex_wd_o),      64'(e.wd));
         check({t, ".wreg"},    64'(bus.ex_wreg_o),    64'(e.wreg));
         check({t, ".pc"},      64'(bus.ex_pc_o),      64'(e.pc));
         check({t, ".invalid"}, 64'(bus.ex_invalid_o), 64'(e.inv));
      end
   endtask

   task automatic idle();
      bus.pc_i        = 32'h0;
      bus.inst_i      = 32'h0;
      bus.id_valid_i  = 1'b0;
      bus.reg1_data_i = 32'h0;
      bus.reg2_data_i = 32'h0;
      bus.fwd_wreg_i  = 2'b00;
      bus.fwd_wd_i    = 10'h0;
      bus.fwd_wdata_i = 64'h0;
      bus.ex_load_i   = 1'b0;
      bus.stall_i     = 1'b0;
      bus.flush_i     = 1'b0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic v);
      bus.pc_i       = pc;
      bus.inst_i     = inst;
      bus.id_valid_i = v;
   endtask

   localparam exp_t ZERO = '0;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      idle();
      // Reset must mask reads and the load-use request even for a hazardous word.
      drive(32'h40, 32'h00221824, 1'b1);
      bus.ex_load_i  = 1'b1;
      bus.fwd_wreg_i = 2'b01;
      bus.fwd_wd_i   = {5'd0, 5'd2};
      #1;
      check("rst_read1", 64'(bus.reg1_read_o), 64'd0);
      check("rst_read2", 64'(bus.reg2_read_o), 64'd0);
      check("rst_stallreq", 64'(bus.stallreq_o), 64'd0);
      expect_ex("reset", ZERO);
      tick();

      rst = 1'b0;
      idle();
      drive(32'h100, 32'h34011100, 1'b1);
      #1;
      check("ori_read1", 64'(bus.reg1_read_o), 64'd1);
      check("ori_read2", 64'(bus.reg2_read_o), 64'd0);
      check("ori_addr2", 64'(bus.reg2_addr_o), 64'd1);
      expect_ex("ori", mk(8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 32'h100, 1'b0));
      tick();

      // Both sources hit $1; EX (index 0) must win.
      idle();
      drive(32'h104, 32'h00221824, 1'b1);
      bus.reg1_data_i = 32'h00001234;
      bus.reg2_data_i = 32'h0000000F;
      bus.fwd_wreg_i  = 2'b11;
      bus.fwd_wd_i    = {5'd1, 5'd1};
      bus.fwd_wdata_i = {32'h00005555, 32'hAAAA0000};
      #1;
      check("and_addr1", 64'(bus.reg1_addr_o), 64'd1);
      check("and_addr2", 64'(bus.reg2_addr_o), 64'd2);
      check("and_stallreq", 64'(bus.stallreq_o), 64'd0);
      expect_ex("and_fwd0", mk(8'h24, 3'd1, 32'hAAAA0000, 32'h0F, 5'd3, 1'b1, 32'h104, 1'b0));
      tick();

      // Only source 1 matches, on rt.
      bus.pc_i        = 32'h108;
      bus.fwd_wreg_i  = 2'b10;
      bus.fwd_wd_i    = {5'd2, 5'd1};
      bus.fwd_wdata_i = {32'h00000077, 32'hDEADBEEF};
      expect_ex("and_fwd1", mk(8'h24, 3'd1, 32'h1234, 32'h77, 5'd3, 1'b1, 32'h108, 1'b0));
      tick();

      // Same match from a non-load EX: forwarded, no stall.
      bus.pc_i        = 32'h10C;
      bus.fwd_wreg_i  = 2'b01;
      bus.fwd_wd_i    = {5'd0, 5'd2};
      bus.fwd_wdata_i = {32'h0, 32'h0BADF00D};
      #1;
      check("nonload_stallreq", 64'(bus.stallreq_o), 64'd0);
      expect_ex("and_nonload", mk(8'h24, 3'd1, 32'h1234, 32'h0BADF00D, 5'd3, 1'b1, 32'h10C, 1'b0));
      tick();

      bus.ex_load_i = 1'b1;
      #1;
      check("loaduse_stallreq", 64'(bus.stallreq_o), 64'd1);
      expect_ex("loaduse", ZERO);
      tick();

      idle();
      drive(32'h110, 32'h3C05ABCD, 1'b1);
      #1;
      check("lui_read1", 64'(bus.reg1_read_o), 64'd0);
      expect_ex("lui", mk(8'h25, 3'd1, 32'h0, 32'hABCD0000, 5'd5, 1'b1, 32'h110, 1'b0));
      tick();

      drive(32'h114, 32'h3860FFFF, 1'b1);
      bus.reg1_data_i = 32'h0F0F0000;
      expect_ex("xori_r0", mk(8'h26, 3'd1, 32'h0F0F0000, 32'h0000FFFF, 5'd0, 1'b0, 32'h114, 1'b0));
      tick();

      drive(32'h118, 32'h00221827, 1'b1);
      bus.reg1_data_i = 32'h1;
      bus.reg2_data_i = 32'h2;
      expect_ex("nor", mk(8'h27, 3'd1, 32'h1, 32'h2, 5'd3, 1'b1, 32'h118, 1'b0));
      tick();

      idle();
      drive(32'h11C, 32'hFC000000, 1'b1);
      expect_ex("invalid", mk(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h11C, 1'b1));
      tick();

      drive(32'h120, 32'h00000000, 1'b1);
      expect_ex("bubble_word", ZERO);
      tick();

      drive(32'h124, 32'h34011100, 1'b0);
      expect_ex("not_valid", ZERO);
      tick();

      drive(32'h128, 32'h00011100, 1'b1);
      bus.reg2_data_i = 32'h80000001;
`ifdef SHIFT_INSTR_EN
      expect_ex("sll", mk(8'h7C, 3'd2, 32'h4, 32'h80000001, 5'd2, 1'b1, 32'h128, 1'b0));
`else
      expect_ex("sll_off", mk(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h128, 1'b1));
`endif
      tick();

      // Stall holds the ori for three cycles; flush with stall still high kills it.
      idle();
      drive(32'h200, 32'h34011100, 1'b1);
      expect_ex("stall_pre", mk(8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1'b1, 32'h200, 1'b0));
      tick();
      bus.stall_i = 1'b1;
      drive(32'h204, 32'h3C05ABCD, 1'b1);
      for (int i = 0; i < 3; i++) begin
         expect_ex($sformatf("stall_hold%0d", i),
                   mk(8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1'b1, 32'h200, 1'b0));
         tick();
      end
      bus.flush_i = 1'b1;
      expect_ex("flush_stall", ZERO);
      tick();

      idle();
      drive(32'h300, 32'h3C05ABCD, 1'b1);
      bus.flush_i = 1'b1;
      expect_ex("flush_only", ZERO);
      tick();

      // Reset while stalled with live contents.
      idle();
      drive(32'h400, 32'h34011100, 1'b1);
      expect_ex("rst_pre", mk(8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1'b1, 32'h400, 1'b0));
      tick();
      bus.stall_i = 1'b1;
      rst = 1'b1;
      expect_ex("rst_in_stall", ZERO);
      tick();
      rst = 1'b0;
      idle();

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
